// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU execute-stage output register.
//   SEL_ADD..SEL_B : ALU mux select / op tag encodings (5-7 are illegal)
//   SEL_MAX        : highest legal select value
//   FLAG_N..FLAG_V : bit positions of NZCV inside a 4-bit flag word
package alu_pkg;

  localparam int SEL_ADD = 0;
  localparam int SEL_AND = 1;
  localparam int SEL_XOR = 2;
  localparam int SEL_OR  = 3;
  localparam int SEL_B   = 4;
  localparam int SEL_MAX = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational NZCV derivation for one ALU result.
// Ports:
//   result  in  WIDTH  selected ALU result
//   sel     in  SEL_W  ALU select of the op that produced result
//   carry   in  1      adder carry-out
//   ovf     in  1      adder signed overflow
//   nzcv    out 4      {N, Z, C, V}; C/V only meaningful for ADD, cleared otherwise
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEL_W = 3
) (
  input  logic [WIDTH-1:0] result,
  input  logic [SEL_W-1:0] sel,
  input  logic             carry,
  input  logic             ovf,
  output logic [3:0]       nzcv
);

  always_comb begin
    nzcv         = 4'b0000;
    nzcv[FLAG_N] = result[WIDTH-1];
    nzcv[FLAG_Z] = (result == '0);
    if (sel == SEL_W'(SEL_ADD)) begin
      nzcv[FLAG_C] = carry;
      nzcv[FLAG_V] = ovf;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: execute-stage output register behind the ALU result mux.
// Captures result + op tag, precomputes NZCV, hands the entry to MEM over
// valid/ready. Flags are committed only when an entry is popped, so flushed
// entries never touch flags_out.
// Build option: define ALU_RESULT_SKID_EN for a 2-entry version whose in_ready
// comes from a flop (no out_ready -> in_ready combinational path).
// Ports:
//   clk, rst_n               clock, async active-low reset
//   in_valid/in_ready        upstream handshake
//   result_in, sel_in        mux output and its select
//   carry_in, ovf_in         adder C/V for this op
//   set_flags                entry requests NZCV update
//   flush                    drop all held entries next edge
//   out_valid/out_ready      downstream handshake
//   result_out, op_out       held entry
//   flags_out                committed NZCV
//   illegal_op               1-cycle pulse after accepting sel_in > SEL_MAX
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] result_in,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             carry_in,
  input  logic             ovf_in,
  input  logic             set_flags,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_out,
  output logic [SEL_W-1:0] op_out,
  output logic [3:0]       flags_out,
  output logic             illegal_op
);

  logic [3:0] nzcv_in;
  logic       illegal_in;
  logic       sf_in;
  logic       accept;
  logic       pop;
  logic       head_sf;
  logic [3:0] head_nzcv;

  alu_flag_gen #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_flag_gen (
    .result (result_in),
    .sel    (sel_in),
    .carry  (carry_in),
    .ovf    (ovf_in),
    .nzcv   (nzcv_in)
  );

  // Illegal ops still flow through, but may never update flags.
  assign illegal_in = (sel_in > SEL_W'(SEL_MAX));
  assign sf_in      = set_flags && !illegal_in;
  assign accept     = in_valid && in_ready;
  // Flush wins over pop: a flushed entry is never committed.
  assign pop        = out_valid && out_ready && !flush;

`ifdef ALU_RESULT_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_result;
  logic [SEL_W-1:0] skid_op;
  logic             skid_sf;
  logic [3:0]       skid_nzcv;

  assign in_ready = rst_n && !flush && !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      result_out  <= '0;
      op_out      <= '0;
      head_sf     <= 1'b0;
      head_nzcv   <= 4'b0000;
      skid_valid  <= 1'b0;
      skid_result <= '0;
      skid_op     <= '0;
      skid_sf     <= 1'b0;
      skid_nzcv   <= 4'b0000;
      flags_out   <= 4'b0000;
      illegal_op  <= 1'b0;
    end else begin
      illegal_op <= accept && illegal_in;
      if (flush) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        if (pop && head_sf) flags_out <= head_nzcv;
        if (pop) begin
          if (skid_valid) begin
            result_out <= skid_result;
            op_out     <= skid_op;
            head_sf    <= skid_sf;
            head_nzcv  <= skid_nzcv;
            skid_valid <= 1'b0;
          end else if (accept) begin
            result_out <= result_in;
            op_out     <= sel_in;
            head_sf    <= sf_in;
            head_nzcv  <= nzcv_in;
          end else begin
            out_valid  <= 1'b0;
          end
        end else if (accept) begin
          if (out_valid) begin
            skid_result <= result_in;
            skid_op     <= sel_in;
            skid_sf     <= sf_in;
            skid_nzcv   <= nzcv_in;
            skid_valid  <= 1'b1;
          end else begin
            result_out <= result_in;
            op_out     <= sel_in;
            head_sf    <= sf_in;
            head_nzcv  <= nzcv_in;
            out_valid  <= 1'b1;
          end
        end
      end
    end
  end
`else
  assign in_ready = rst_n && !flush && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result_out <= '0;
      op_out     <= '0;
      head_sf    <= 1'b0;
      head_nzcv  <= 4'b0000;
      flags_out  <= 4'b0000;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= accept && illegal_in;
      if (flush) begin
        out_valid <= 1'b0;
      end else begin
        if (pop && head_sf) flags_out <= head_nzcv;
        if (accept) begin
          result_out <= result_in;
          op_out     <= sel_in;
          head_sf    <= sf_in;
          head_nzcv  <= nzcv_in;
          out_valid  <= 1'b1;
        end else if (pop) begin
          out_valid  <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed self-checking bench for alu_result_stage
// (default single-entry build).
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] result_in;
  logic [2:0]  sel_in;
  logic        carry_in;
  logic        ovf_in;
  logic        set_flags;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result_out;
  logic [2:0]  op_out;
  logic [3:0]  flags_out;
  logic        illegal_op;

  int errors = 0;
  int checks = 0;

  alu_result_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .result_in  (result_in),
    .sel_in     (sel_in),
    .carry_in   (carry_in),
    .ovf_in     (ovf_in),
    .set_flags  (set_flags),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_out (result_out),
    .op_out     (op_out),
    .flags_out  (flags_out),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] r, input logic [2:0] s, input logic c,
                       input logic v, input logic sf);
    in_valid  = 1'b1;
    result_in = r;
    sel_in    = s;
    carry_in  = c;
    ovf_in    = v;
    set_flags = sf;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; result_in = '0; sel_in = '0; carry_in = 1'b0;
    ovf_in = 1'b0; set_flags = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_flags", 64'(flags_out), 64'h0);
    chk("rst_result", result_out, 64'h0);
    chk("rst_illegal", 64'(illegal_op), 64'h0);
    rst_n = 1'b1;
    step();

    // 1: ADD zero result with carry -> Z,C
    drive(64'h0, 3'd0, 1'b1, 1'b0, 1'b1);
    chk("t1_in_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", 64'(out_valid), 64'h1);
    chk("t1_result", result_out, 64'h0);
    chk("t1_flags_before_pop", 64'(flags_out), 64'h0);
    step();
    chk("t1_flags", 64'(flags_out), 64'h6);
    chk("t1_popped", 64'(out_valid), 64'h0);

    // 2: AND with msb set, carry ignored -> N only
    drive(64'h8000_0000_0000_0000, 3'd1, 1'b1, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t2_result", result_out, 64'h8000_0000_0000_0000);
    chk("t2_op", 64'(op_out), 64'h1);
    step();
    chk("t2_flags", 64'(flags_out), 64'h8);

    // 2b: ADD negative with carry and overflow -> N,C,V
    drive(64'h8000_0000_0000_0001, 3'd0, 1'b1, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    chk("t2b_flags", 64'(flags_out), 64'hB);

    // 3: stall with three back-to-back entries, no flag updates
    out_ready = 1'b0;
    drive(64'd1, 3'd4, 1'b0, 1'b0, 1'b0);
    step();
    chk("t3_first", result_out, 64'd1);
    chk("t3_in_ready_drop", 64'(in_ready), 64'h0);
    result_in = 64'd2;
    step();
    step();
    chk("t3_hold", result_out, 64'd1);
    chk("t3_hold_valid", 64'(out_valid), 64'h1);
    chk("t3_in_ready_stall", 64'(in_ready), 64'h0);
    out_ready = 1'b1;
    #1;
    chk("t3_in_ready_release", 64'(in_ready), 64'h1);
    step();
    chk("t3_second", result_out, 64'd2);
    result_in = 64'd3;
    step();
    chk("t3_third", result_out, 64'd3);
    chk("t3_third_valid", 64'(out_valid), 64'h1);
    in_valid = 1'b0;
    step();
    chk("t3_drained", 64'(out_valid), 64'h0);
    chk("t3_flags_kept", 64'(flags_out), 64'hB);

    // 4: flush beats a simultaneous pop
    out_ready = 1'b0;
    drive(64'd5, 3'd0, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t4_valid", 64'(out_valid), 64'h1);
    chk("t4_result", result_out, 64'd5);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t4_in_ready_flush", 64'(in_ready), 64'h0);
    step();
    flush = 1'b0;
    chk("t4_flushed", 64'(out_valid), 64'h0);
    chk("t4_result_kept", result_out, 64'd5);
    chk("t4_flags_kept", 64'(flags_out), 64'hB);
    step();
    chk("t4_flags_later", 64'(flags_out), 64'hB);

    // 5: illegal select
    out_ready = 1'b0;
    drive(64'hDEAD, 3'd6, 1'b1, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t5_illegal_pulse", 64'(illegal_op), 64'h1);
    chk("t5_result", result_out, 64'hDEAD);
    chk("t5_op", 64'(op_out), 64'h6);
    out_ready = 1'b1;
    step();
    chk("t5_illegal_end", 64'(illegal_op), 64'h0);
    chk("t5_popped", 64'(out_valid), 64'h0);
    chk("t5_flags_kept", 64'(flags_out), 64'hB);

    // 6: asynchronous reset mid-stall
    out_ready = 1'b0;
    drive(64'd9, 3'd0, 1'b1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t6_valid", 64'(out_valid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid), 64'h0);
    chk("t6_async_flags", 64'(flags_out), 64'h0);
    chk("t6_async_result", result_out, 64'h0);
    chk("t6_async_in_ready", 64'(in_ready), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
